// File: rtl/led_matrix_pwm_scan.sv
// rtl/led_matrix_pwm_scan.sv - row-scanned PWM driver for an LED matrix with double-buffered frame store
// Pixel word: [BW] blink flag, [BW-1:0] brightness; top PWM step is a dark guard step.
module led_matrix_pwm_scan #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int BW       = 4,
  parameter int PRESCALE = 16,
  parameter int BLINK_W  = 23,
  localparam int ADDR_W  = $clog2(ROWS * COLS)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BW:0]       wr_data,
  input  logic              swap_req,
  output logic              swap_pending,
  output logic [ROWS-1:0]   aled,
  output logic [COLS-1:0]   kled_oe,
  output logic              frame_strobe
);

  localparam int NPIX  = ROWS * COLS;
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int ROW_W = $clog2(ROWS);
  localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(PRESCALE - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [BW-1:0]     PWM_MAX = '1;
  localparam logic [ADDR_W:0]   NPIX_V  = (ADDR_W + 1)'(NPIX);

  logic [PRE_W-1:0]   pre_cnt;
  logic [BW-1:0]      pwm_cnt;
  logic [ROW_W-1:0]   row_idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic               front_sel;
  logic [BW:0]        mem [2][NPIX];

  logic            tick;
  logic            row_end;
  logic            boundary;
  logic [COLS-1:0] lit;

  assign tick     = en && (pre_cnt == PRE_MAX);
  assign row_end  = tick && (pwm_cnt == PWM_MAX);
  assign boundary = row_end && (row_idx == ROW_MAX);

  // Per-column lit decision from the front buffer row currently being scanned.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [ADDR_W-1:0] idx;
    logic [BW:0]       pix;
    assign idx    = ADDR_W'(row_idx * COLS + c);
    assign pix    = mem[front_sel][idx];
    assign lit[c] = en && (pix[BW-1:0] > pwm_cnt) && !(pix[BW] && blink_phase);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre_cnt      <= '0;
      pwm_cnt      <= '0;
      row_idx      <= '0;
      blink_cnt    <= '0;
      blink_phase  <= 1'b0;
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      aled         <= '0;
      kled_oe      <= '0;
      frame_strobe <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < NPIX; i++)
          mem[b][i] <= '0;
    end else begin
      if (en) begin
        pre_cnt   <= tick ? '0 : pre_cnt + 1'b1;
        blink_cnt <= blink_cnt + 1'b1;
        if (blink_cnt == '1)
          blink_phase <= ~blink_phase;
        if (tick)
          pwm_cnt <= pwm_cnt + 1'b1;
        if (row_end)
          row_idx <= (row_idx == ROW_MAX) ? '0 : row_idx + 1'b1;
      end

      // A request arriving in the boundary cycle is served immediately.
      if (boundary && (swap_pending || swap_req)) begin
        front_sel    <= ~front_sel;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end

      if (wr_en && ({1'b0, wr_addr} < NPIX_V))
        mem[~front_sel][wr_addr] <= wr_data;

      aled         <= en ? ({{(ROWS-1){1'b0}}, 1'b1} << row_idx) : '0;
      kled_oe      <= lit;
      frame_strobe <= boundary;
    end
  end

endmodule

// File: tb/tb_led_matrix_pwm_scan.sv
// tb/tb_led_matrix_pwm_scan.sv - directed self-checking bench for led_matrix_pwm_scan
module tb_led_matrix_pwm_scan;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       en = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [2:0] wr_data = '0;
  logic       swap_req = 1'b0;
  logic       swap_pending;
  logic [3:0] aled;
  logic [3:0] kled_oe;
  logic       frame_strobe;

  // Second instance with a non power-of-two pixel count so out-of-range addresses exist.
  logic       wr_en2 = 1'b0;
  logic [2:0] wr_addr2 = '0;
  logic [2:0] wr_data2 = '0;
  logic       swap_req2 = 1'b0;
  logic       swap_pending2;
  logic [1:0] aled2;
  logic [2:0] kled2;
  logic       frame_strobe2;

  int n_cmp = 0;
  int n_bad = 0;
  int pos = 0;

  always #5 clk = ~clk;

  led_matrix_pwm_scan #(.ROWS(4), .COLS(4), .BW(2), .PRESCALE(2), .BLINK_W(6)) dut (
    .clk(clk), .resetn(resetn), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .swap_req(swap_req), .swap_pending(swap_pending),
    .aled(aled), .kled_oe(kled_oe), .frame_strobe(frame_strobe)
  );

  led_matrix_pwm_scan #(.ROWS(2), .COLS(3), .BW(2), .PRESCALE(2), .BLINK_W(6)) dut_odd (
    .clk(clk), .resetn(resetn), .en(en), .wr_en(wr_en2), .wr_addr(wr_addr2),
    .wr_data(wr_data2), .swap_req(swap_req2), .swap_pending(swap_pending2),
    .aled(aled2), .kled_oe(kled2), .frame_strobe(frame_strobe2)
  );

  // pos counts enabled, out-of-reset edges; outputs after an edge reflect state at pos-1.
  task automatic step();
    logic e;
    e = en && resetn;
    @(posedge clk);
    #1;
    if (e) pos++;
  endtask

  task automatic test_reset();
    resetn = 1'b0; en = 1'b0;
    repeat (3) step();
    n_cmp++; if (aled !== 4'b0) begin n_bad++; $display("FAIL reset_aled got=%b exp=0000", aled); end
    n_cmp++; if (kled_oe !== 4'b0) begin n_bad++; $display("FAIL reset_kled got=%b exp=0000", kled_oe); end
    n_cmp++; if (frame_strobe !== 1'b0) begin n_bad++; $display("FAIL reset_strobe got=%b exp=0", frame_strobe); end
    n_cmp++; if (swap_pending !== 1'b0) begin n_bad++; $display("FAIL reset_pending got=%b exp=0", swap_pending); end
    n_cmp++; if (aled2 !== 2'b0) begin n_bad++; $display("FAIL reset_aled2 got=%b exp=00", aled2); end
    resetn = 1'b1; en = 1'b1; pos = 0;
  endtask

  task automatic test_scan_walk();
    int b;
    logic [3:0] exp_a;
    for (int i = 0; i < 64; i++) begin
      step(); b = pos - 1;
      exp_a = 4'b0001 << ((b / 8) % 4);
      n_cmp++; if (aled !== exp_a) begin n_bad++; $display("FAIL walk_aled pos=%0d got=%b exp=%b", pos, aled, exp_a); end
      n_cmp++; if (kled_oe !== 4'b0) begin n_bad++; $display("FAIL walk_kled pos=%0d got=%b exp=0000", pos, kled_oe); end
      n_cmp++; if (frame_strobe !== (pos % 32 == 0)) begin n_bad++; $display("FAIL walk_strobe pos=%0d got=%b exp=%b", pos, frame_strobe, pos % 32 == 0); end
    end
  endtask

  task automatic test_swap_pixel();
    int b;
    logic got;
    logic [3:0] exp_k;
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 3'b010; step(); wr_en = 1'b0;
    swap_req = 1'b1; step(); swap_req = 1'b0;
    n_cmp++; if (swap_pending !== 1'b1) begin n_bad++; $display("FAIL swap_pending_set got=%b exp=1", swap_pending); end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      got = frame_strobe;
      n_cmp++; if (kled_oe !== 4'b0) begin n_bad++; $display("FAIL preswap_kled pos=%0d got=%b exp=0000", pos, kled_oe); end
    end
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL swap_strobe_wait got=%b exp=1", got); end
    n_cmp++; if (swap_pending !== 1'b0) begin n_bad++; $display("FAIL swap_pending_clr got=%b exp=0", swap_pending); end
    for (int i = 0; i < 32; i++) begin
      step(); b = pos - 1;
      exp_k = ((b / 8) % 4 == 1 && (b / 2) % 4 < 2) ? 4'b0010 : 4'b0000;
      n_cmp++; if (kled_oe !== exp_k) begin n_bad++; $display("FAIL px5_kled pos=%0d got=%b exp=%b", pos, kled_oe, exp_k); end
    end
  endtask

  task automatic test_blink();
    int b;
    logic [3:0] exp_k;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 3'b111; swap_req = 1'b1; step();
    wr_en = 1'b0; swap_req = 1'b0;
    for (int i = 0; i < 40 && (pos % 32 != 0); i++) step();
    n_cmp++; if (pos % 32 !== 0) begin n_bad++; $display("FAIL blink_align pos=%0d exp=multiple of 32", pos); end
    for (int i = 0; i < 128; i++) begin
      step(); b = pos - 1;
      exp_k = ((b / 8) % 4 == 0 && (b / 2) % 4 < 3 && (b / 64) % 2 == 0) ? 4'b0001 : 4'b0000;
      n_cmp++; if (kled_oe !== exp_k) begin n_bad++; $display("FAIL blink_kled pos=%0d got=%b exp=%b", pos, kled_oe, exp_k); end
    end
  endtask

  task automatic test_boundary_swap();
    int b;
    logic [3:0] exp_k;
    logic exp_p;
    for (int i = 0; i < 40 && (pos % 32 != 31); i++) step();
    swap_req = 1'b1; wr_en = 1'b1; wr_addr = 4'd10; wr_data = 3'b001;
    step();
    swap_req = 1'b0; wr_en = 1'b0;
    n_cmp++; if (frame_strobe !== 1'b1) begin n_bad++; $display("FAIL bnd_strobe pos=%0d got=%b exp=1", pos, frame_strobe); end
    n_cmp++; if (swap_pending !== 1'b0) begin n_bad++; $display("FAIL bnd_pending pos=%0d got=%b exp=0", pos, swap_pending); end
    for (int i = 0; i < 64; i++) begin
      swap_req = (i == 20 || i == 25);
      step(); b = pos - 1;
      swap_req = 1'b0;
      exp_p = (i >= 20 && i < 31);
      if (b < 352)
        exp_k = ((b / 8) % 4 == 1 && (b / 2) % 4 < 2) ? 4'b0010 :
                ((b / 8) % 4 == 2 && (b / 2) % 4 < 1) ? 4'b0100 : 4'b0000;
      else
        exp_k = 4'b0000;
      n_cmp++; if (swap_pending !== exp_p) begin n_bad++; $display("FAIL bnd_pend_seq pos=%0d got=%b exp=%b", pos, swap_pending, exp_p); end
      n_cmp++; if (kled_oe !== exp_k) begin n_bad++; $display("FAIL bnd_kled pos=%0d got=%b exp=%b", pos, kled_oe, exp_k); end
    end
  endtask

  task automatic test_en_pause();
    int b;
    logic [3:0] exp_a;
    logic [3:0] exp_k;
    for (int i = 0; i < 3; i++) step();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++; if (aled !== 4'b0) begin n_bad++; $display("FAIL pause_aled i=%0d got=%b exp=0000", i, aled); end
      n_cmp++; if (kled_oe !== 4'b0) begin n_bad++; $display("FAIL pause_kled i=%0d got=%b exp=0000", i, kled_oe); end
    end
    en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step(); b = pos - 1;
      exp_a = 4'b0001 << ((b / 8) % 4);
      exp_k = ((b / 8) % 4 == 0 && (b / 2) % 4 < 3 && (b / 64) % 2 == 0) ? 4'b0001 : 4'b0000;
      n_cmp++; if (aled !== exp_a) begin n_bad++; $display("FAIL resume_aled pos=%0d got=%b exp=%b", pos, aled, exp_a); end
      n_cmp++; if (kled_oe !== exp_k) begin n_bad++; $display("FAIL resume_kled pos=%0d got=%b exp=%b", pos, kled_oe, exp_k); end
      n_cmp++; if (frame_strobe !== (pos % 32 == 0)) begin n_bad++; $display("FAIL resume_strobe pos=%0d got=%b exp=%b", pos, frame_strobe, pos % 32 == 0); end
    end
  endtask

  task automatic test_reset_midframe();
    int b;
    logic [3:0] exp_a;
    logic [1:0] exp_a2;
    logic [2:0] exp_k2;
    swap_req = 1'b1; step(); swap_req = 1'b0;
    for (int i = 0; i < 40 && (pos % 32 != 10); i++) step();
    n_cmp++; if (aled !== 4'b0010) begin n_bad++; $display("FAIL mid_aled_pre got=%b exp=0010", aled); end
    n_cmp++; if (swap_pending !== 1'b1) begin n_bad++; $display("FAIL mid_pending_pre got=%b exp=1", swap_pending); end
    resetn = 1'b0;
    #1;
    n_cmp++; if (aled !== 4'b0) begin n_bad++; $display("FAIL async_aled got=%b exp=0000", aled); end
    n_cmp++; if (kled_oe !== 4'b0) begin n_bad++; $display("FAIL async_kled got=%b exp=0000", kled_oe); end
    n_cmp++; if (swap_pending !== 1'b0) begin n_bad++; $display("FAIL async_pending got=%b exp=0", swap_pending); end
    step(); step();
    resetn = 1'b1; pos = 0;
    for (int i = 0; i < 64; i++) begin
      wr_en2 = (i < 3);
      wr_addr2 = (i == 0) ? 3'd6 : (i == 1) ? 3'd7 : 3'd5;
      wr_data2 = (i < 2) ? 3'b011 : 3'b010;
      swap_req2 = (i == 0);
      swap_req = (i == 0);
      step(); b = pos - 1;
      wr_en2 = 1'b0; swap_req2 = 1'b0; swap_req = 1'b0;
      exp_a = 4'b0001 << ((b / 8) % 4);
      exp_a2 = 2'b01 << ((b / 8) % 2);
      exp_k2 = (b >= 16 && (b / 8) % 2 == 1 && (b / 2) % 4 < 2) ? 3'b100 : 3'b000;
      n_cmp++; if (aled !== exp_a) begin n_bad++; $display("FAIL rst_aled pos=%0d got=%b exp=%b", pos, aled, exp_a); end
      n_cmp++; if (kled_oe !== 4'b0) begin n_bad++; $display("FAIL rst_kled_cleared pos=%0d got=%b exp=0000", pos, kled_oe); end
      n_cmp++; if (swap_pending !== (pos < 32)) begin n_bad++; $display("FAIL rst_pending pos=%0d got=%b exp=%b", pos, swap_pending, pos < 32); end
      n_cmp++; if (aled2 !== exp_a2) begin n_bad++; $display("FAIL odd_aled pos=%0d got=%b exp=%b", pos, aled2, exp_a2); end
      n_cmp++; if (kled2 !== exp_k2) begin n_bad++; $display("FAIL odd_kled_oob pos=%0d got=%b exp=%b", pos, kled2, exp_k2); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan_walk();
    test_swap_pixel();
    test_blink();
    test_boundary_swap();
    test_en_pause();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
